fe_fetch_ctrl: RTL and testbench

Front-end fetch sequencer that owns the program counter and drives the asynchronous-read instruction ROM. Each cycle it presents the PC as the ROM address and captures the returned word together with its PC into a 2-entry fetch queue. Decode drains the queue through a valid/ready handshake. Backend redirects flush the queue and reload the PC; a halt request parks the fetch engine until the next redirect.

---
 rtl/fe_fetch_ctrl.sv | 93 +++++++++
 tb/tb_fe_fetch_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fe_fetch_ctrl.sv
// Front-end fetch sequencer: owns the PC, reads the asynchronous ROM each cycle
// and buffers {pc, word} in a 2-entry queue drained by decode via valid/ready.
module fe_fetch_ctrl #(
  parameter  int I_CACHE_DEPTH_P = 256,
  parameter  int WORD_SIZE_P     = 16,
  parameter  int RESET_PC_P      = 0,
  localparam int ADDR_WIDTH_LP   = $clog2(I_CACHE_DEPTH_P)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  output logic [ADDR_WIDTH_LP-1:0] rom_addr_o,
  input  logic [WORD_SIZE_P-1:0]   rom_data_i,
  input  logic                     redirect_v_i,
  input  logic [ADDR_WIDTH_LP-1:0] redirect_pc_i,
  input  logic                     halt_i,
  output logic                     fetch_v_o,
  output logic [WORD_SIZE_P-1:0]   fetch_instr_o,
  output logic [ADDR_WIDTH_LP-1:0] fetch_pc_o,
  input  logic                     fetch_ready_i,
  output logic                     halted_o
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t                   state_r;
  logic [ADDR_WIDTH_LP-1:0] pc_r;
  logic                     head_r;
  logic                     tail_r;
  logic [1:0]               count_r;

  logic [ADDR_WIDTH_LP-1:0] pc_q    [2];
  logic [WORD_SIZE_P-1:0]   instr_q [2];

  logic deq;
  logic enq;

  // Depth is a power of two, so dropping the carry gives the modulo wrap.
  function automatic logic [ADDR_WIDTH_LP-1:0] pc_next(input logic [ADDR_WIDTH_LP-1:0] pc);
    return pc + ADDR_WIDTH_LP'(1);
  endfunction

  assign rom_addr_o    = pc_r;
  assign fetch_v_o     = (count_r != 2'd0) & ~redirect_v_i;
  assign fetch_instr_o = instr_q[head_r];
  assign fetch_pc_o    = pc_q[head_r];
  assign halted_o      = (state_r == HALTED);

  assign deq = fetch_v_o & fetch_ready_i;
  // A full queue can still accept a word when the head leaves in the same cycle.
  assign enq = (state_r == RUN) & ~redirect_v_i & ~halt_i & ((count_r != 2'd2) | deq);

  // Control state: PC, pointers, occupancy and run/halt.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= RUN;
      pc_r    <= ADDR_WIDTH_LP'(RESET_PC_P);
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      count_r <= 2'd0;
    end else if (redirect_v_i) begin
      state_r <= RUN;
      pc_r    <= redirect_pc_i;
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq) begin
        pc_r   <= pc_next(pc_r);
        tail_r <= ~tail_r;
      end
      if (deq) begin
        head_r <= ~head_r;
      end
      case ({enq, deq})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
      if (halt_i && state_r == RUN) begin
        state_r <= HALTED;
      end
    end
  end

  // Queue storage: payload only, validity is tracked by count_r.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      pc_q[tail_r]    <= pc_r;
      instr_q[tail_r] <= rom_data_i;
    end
  end

endmodule

// File: tb/tb_fe_fetch_ctrl.sv
// Bench for fe_fetch_ctrl: a 256-deep and an 8-deep instance share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_fe_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_v = 1'b0;
  logic        halt = 1'b0;
  logic        fetch_ready = 1'b0;

  logic [7:0]  redirect_pc0 = '0;
  logic [7:0]  rom_addr0;
  logic [15:0] rom_data0;
  logic        fetch_v0;
  logic [15:0] fetch_instr0;
  logic [7:0]  fetch_pc0;
  logic        halted0;

  logic [2:0]  redirect_pc1 = '0;
  logic [2:0]  rom_addr1;
  logic [15:0] rom_data1;
  logic        fetch_v1;
  logic [15:0] fetch_instr1;
  logic [2:0]  fetch_pc1;
  logic        halted1;

  always #5 clk = ~clk;

  assign rom_data0 = 16'hA000 + 16'(rom_addr0);
  assign rom_data1 = 16'hA000 + 16'(rom_addr1);

  fe_fetch_ctrl #(.I_CACHE_DEPTH_P(256), .WORD_SIZE_P(16), .RESET_PC_P(0)) u0 (
    .clk_i(clk), .reset_n_i(reset_n),
    .rom_addr_o(rom_addr0), .rom_data_i(rom_data0),
    .redirect_v_i(redirect_v), .redirect_pc_i(redirect_pc0), .halt_i(halt),
    .fetch_v_o(fetch_v0), .fetch_instr_o(fetch_instr0), .fetch_pc_o(fetch_pc0),
    .fetch_ready_i(fetch_ready), .halted_o(halted0)
  );

  fe_fetch_ctrl #(.I_CACHE_DEPTH_P(8), .WORD_SIZE_P(16), .RESET_PC_P(0)) u1 (
    .clk_i(clk), .reset_n_i(reset_n),
    .rom_addr_o(rom_addr1), .rom_data_i(rom_data1),
    .redirect_v_i(redirect_v), .redirect_pc_i(redirect_pc1), .halt_i(halt),
    .fetch_v_o(fetch_v1), .fetch_instr_o(fetch_instr1), .fetch_pc_o(fetch_pc1),
    .fetch_ready_i(fetch_ready), .halted_o(halted1)
  );

  // Reference model: per instance, the queued PCs, the next PC and the halt flag.
  int DEP [2] = '{256, 8};
  int mq  [2][$];
  int m_pc[2];
  bit m_h [2];
  bit m_init = 1'b0;

  int total = 0;
  int pass  = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic v, input logic [7:0] pc,
                           input logic [15:0] ins, input logic h, input logic [7:0] ra);
    bit exp_v;
    exp_v = (mq[d].size() != 0) && !redirect_v;
    chk($sformatf("d%0d_fetch_v", d), 32'(v), 32'(exp_v));
    if (exp_v) begin
      chk($sformatf("d%0d_fetch_pc", d), 32'(pc), 32'(mq[d][0]));
      chk($sformatf("d%0d_fetch_instr", d), 32'(ins), 32'(16'hA000 + mq[d][0]));
    end
    chk($sformatf("d%0d_halted", d), 32'(h), 32'(m_h[d]));
    chk($sformatf("d%0d_rom_addr", d), 32'(ra), 32'(m_pc[d]));
  endtask

  task automatic model_step(input bit rdy, input bit redir, input int rpc,
                            input bit hlt, input bit rn);
    for (int d = 0; d < 2; d++) begin
      if (!rn) begin
        mq[d].delete();
        m_pc[d] = 0;
        m_h[d]  = 1'b0;
      end else if (m_init) begin
        if (redir) begin
          mq[d].delete();
          m_pc[d] = rpc % DEP[d];
          m_h[d]  = 1'b0;
        end else begin
          int  sz;
          bit  take;
          sz   = mq[d].size();
          take = (sz != 0) && rdy;
          if (take) void'(mq[d].pop_front());
          if (!m_h[d] && !hlt && (sz < 2 || take)) begin
            mq[d].push_back(m_pc[d]);
            m_pc[d] = (m_pc[d] + 1) % DEP[d];
          end
          if (hlt) m_h[d] = 1'b1;
        end
      end
    end
    if (!rn) m_init = 1'b1;
  endtask

  task automatic cyc(input bit rdy, input bit redir, input int rpc, input bit hlt, input bit rn);
    @(negedge clk);
    fetch_ready  = rdy;
    redirect_v   = redir;
    redirect_pc0 = 8'(rpc);
    redirect_pc1 = 3'(rpc);
    halt         = hlt;
    reset_n      = rn;
    #1;
    if (m_init) begin
      check_dut(0, fetch_v0, fetch_pc0, fetch_instr0, halted0, rom_addr0);
      check_dut(1, fetch_v1, 8'(fetch_pc1), fetch_instr1, halted1, 8'(rom_addr1));
    end
    @(posedge clk);
    model_step(rdy, redir, rpc, hlt, rn);
  endtask

  initial begin
    // reset, then streaming long enough to wrap the 8-deep instance
    repeat (2) cyc(1, 0, 0, 0, 0);
    repeat (12) cyc(1, 0, 0, 0, 1);
    // backpressure
    repeat (4) cyc(0, 0, 0, 0, 1);
    repeat (6) cyc(1, 0, 0, 0, 1);
    // redirect while full
    repeat (3) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 5, 0, 1);
    repeat (6) cyc(1, 0, 0, 0, 1);
    // halt, drain, idle, extra halt while halted, then redirect out
    cyc(1, 0, 0, 1, 1);
    repeat (6) cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 1);
    repeat (7) cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 3, 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 1);
    // halt and redirect together
    cyc(1, 1, 6, 1, 1);
    repeat (4) cyc(1, 0, 0, 0, 1);
    // reset while full
    repeat (3) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 1);
    // randomized traffic
    repeat (500) begin
      bit rdy, redir, hlt, rn;
      int rpc;
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 19) == 0);
      hlt   = ($urandom_range(0, 24) == 0);
      rn    = ($urandom_range(0, 99) != 0);
      rpc   = int'($urandom_range(0, 255));
      cyc(rdy, redir, rpc, hlt, rn);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
